// File: rtl/bpi_pkg.sv
// bpi_pkg: shared opcodes, flash command codes, status bits and state encodings
// for the BPI command sequencer and its bus-op engine.
package bpi_pkg;

    localparam logic [2:0] OPC_READ_ARRAY   = 3'd0;
    localparam logic [2:0] OPC_PROGRAM      = 3'd1;
    localparam logic [2:0] OPC_BLOCK_ERASE  = 3'd2;
    localparam logic [2:0] OPC_UNLOCK       = 3'd3;
    localparam logic [2:0] OPC_READ_STATUS  = 3'd4;
    localparam logic [2:0] OPC_CLEAR_STATUS = 3'd5;

    localparam logic [15:0] FC_READ_ARRAY   = 16'h00FF;
    localparam logic [15:0] FC_PROGRAM      = 16'h0040;
    localparam logic [15:0] FC_ERASE        = 16'h0020;
    localparam logic [15:0] FC_CONFIRM      = 16'h00D0;
    localparam logic [15:0] FC_UNLOCK       = 16'h0060;
    localparam logic [15:0] FC_READ_STATUS  = 16'h0070;
    localparam logic [15:0] FC_CLEAR_STATUS = 16'h0050;

    localparam int SR_READY   = 7;
    localparam int SR_ERR_MSB = 5;
    localparam int SR_ERR_LSB = 1;

    localparam logic [7:0] STATUS_RST = 8'h80;

    typedef enum logic [1:0] {ST_IDLE, ST_OP, ST_NEXT, ST_FINISH} seq_state_e;
    typedef enum logic [1:0] {OP_IDLE, OP_ISSUE, OP_WAIT_HI, OP_WAIT_LO} op_state_e;

    typedef struct packed {
        logic        rd;
        logic [15:0] word;
    } bus_op_t;

    function automatic logic is_legal(input logic [2:0] cmd);
        return cmd <= OPC_CLEAR_STATUS;
    endfunction

    function automatic logic is_poll(input logic [2:0] cmd);
        return cmd == OPC_PROGRAM || cmd == OPC_BLOCK_ERASE;
    endfunction

    // Polling commands count their read-status write as the third table op.
    function automatic logic [1:0] seq_len(input logic [2:0] cmd);
        return is_poll(cmd) ? 2'd3 : (cmd == OPC_CLEAR_STATUS) ? 2'd1 : 2'd2;
    endfunction

    function automatic bus_op_t seq_op(input logic [2:0] cmd, input logic [1:0] step,
                                       input logic [15:0] data);
        bus_op_t op;
        op.rd = (cmd == OPC_READ_ARRAY || cmd == OPC_READ_STATUS) && step == 2'd1;
        op.word = (step == 2'd0) ?
                      ((cmd == OPC_READ_ARRAY)  ? FC_READ_ARRAY  :
                       (cmd == OPC_PROGRAM)     ? FC_PROGRAM     :
                       (cmd == OPC_BLOCK_ERASE) ? FC_ERASE       :
                       (cmd == OPC_UNLOCK)      ? FC_UNLOCK      :
                       (cmd == OPC_READ_STATUS) ? FC_READ_STATUS : FC_CLEAR_STATUS) :
                  (step == 2'd1) ? ((cmd == OPC_PROGRAM) ? data : FC_CONFIRM) :
                  FC_READ_STATUS;
        return op;
    endfunction

endpackage

// File: rtl/bpi_bus_op.sv
// bpi_bus_op: single bus-op handshake engine; issues one EXECUTE, tracks BUSY
// high then low, and captures read data on LOAD.
module bpi_bus_op
    import bpi_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_b,
    input  logic        i_start,
    input  logic        i_rd,
    input  logic [22:0] i_addr,
    input  logic [15:0] i_wdata,
    input  logic        i_busy,
    input  logic        i_load,
    input  logic [15:0] i_din,
    output logic        o_execute,
    output logic        o_read,
    output logic        o_write,
    output logic [22:0] o_addr,
    output logic [15:0] o_dout,
    output logic        o_done,
    output logic        o_load,
    output logic [15:0] o_rd_data
);

    op_state_e   r_state;
    logic        r_execute;
    logic        r_read;
    logic        r_write;
    logic [22:0] r_addr;
    logic [15:0] r_dout;
    logic [15:0] r_rd_data;

    assign o_execute = r_execute;
    assign o_read    = r_read;
    assign o_write   = r_write;
    assign o_addr    = r_addr;
    assign o_dout    = r_dout;
    assign o_rd_data = r_rd_data;
    assign o_done    = r_state == OP_WAIT_LO && !i_busy;
    assign o_load    = i_load && r_read;

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_state   <= OP_IDLE;
            r_execute <= 1'b0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_dout    <= '0;
            r_rd_data <= '0;
        end else begin
            if (o_load)
                r_rd_data <= i_din;
            case (r_state)
                OP_IDLE: if (i_start) begin
                    r_state   <= OP_ISSUE;
                    r_execute <= 1'b1;
                    r_read    <= i_rd;
                    r_write   <= !i_rd;
                    r_addr    <= i_addr;
                    if (!i_rd)
                        r_dout <= i_wdata;
                end
                OP_ISSUE: begin
                    r_execute <= 1'b0;
                    r_state   <= OP_WAIT_HI;
                end
                OP_WAIT_HI: if (i_busy)
                    r_state <= OP_WAIT_LO;
                default: if (!i_busy) begin
                    r_state <= OP_IDLE;
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bpi_cmd_seq.sv
// bpi_cmd_seq: expands high-level flash commands into BPI bus-op sequences,
// polls status for program/erase and reports completion with an error flag.
module bpi_cmd_seq
    import bpi_pkg::*;
#(
    parameter logic [19:0] POLL_LIMIT = 20'd1000000
) (
    input  logic        i_clk,
    input  logic        i_rst_b,
    input  logic        i_cmd_valid,
    input  logic [2:0]  i_cmd,
    input  logic [22:0] i_cmd_addr,
    input  logic [15:0] i_cmd_data,
    output logic        o_cmd_ready,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_rd_data,
    output logic [7:0]  o_status,
    output logic        o_execute,
    output logic        o_read,
    output logic        o_write,
    output logic [22:0] o_addr,
    output logic [15:0] o_dout,
    input  logic        i_busy,
    input  logic        i_load,
    input  logic [15:0] i_din
);

    seq_state_e  r_state;
    logic [2:0]  r_cmd;
    logic [22:0] r_addr;
    logic [15:0] r_data;
    logic [1:0]  r_step;
    logic [19:0] r_cnt;
    logic [7:0]  r_status;
    logic        r_done;
    logic        r_err;
    logic        r_ready;

    logic        w_idle;
    logic        w_accept;
    logic        w_more;
    logic        w_ready_exit;
    logic        w_poll_rd;
    logic        w_start;
    logic        w_op_done;
    logic        w_load;
    bus_op_t     w_op;

    assign o_cmd_ready = r_ready;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_status    = r_status;

    assign w_idle       = r_state == ST_IDLE;
    assign w_accept     = i_cmd_valid && r_ready;
    assign w_more       = r_state == ST_NEXT && r_step < seq_len(r_cmd);
    // A nonzero count guards against the stale ready bit left by earlier commands.
    assign w_ready_exit = r_cnt != 20'd0 && r_status[SR_READY];
    assign w_poll_rd    = r_state == ST_NEXT && !w_more && is_poll(r_cmd) &&
                          !w_ready_exit && r_cnt < POLL_LIMIT;
    assign w_start      = (w_accept && is_legal(i_cmd)) || w_more || w_poll_rd;
    assign w_op         = seq_op(w_idle ? i_cmd : r_cmd, w_idle ? 2'd0 : r_step,
                                 w_idle ? i_cmd_data : r_data);

    bpi_bus_op u_bus_op (
        .i_clk     (i_clk),
        .i_rst_b   (i_rst_b),
        .i_start   (w_start),
        .i_rd      (w_op.rd || w_poll_rd),
        .i_addr    (w_idle ? i_cmd_addr : r_addr),
        .i_wdata   (w_op.word),
        .i_busy    (i_busy),
        .i_load    (i_load),
        .i_din     (i_din),
        .o_execute (o_execute),
        .o_read    (o_read),
        .o_write   (o_write),
        .o_addr    (o_addr),
        .o_dout    (o_dout),
        .o_done    (w_op_done),
        .o_load    (w_load),
        .o_rd_data (o_rd_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_state  <= ST_IDLE;
            r_cmd    <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_step   <= '0;
            r_cnt    <= '0;
            r_status <= STATUS_RST;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_load && r_cmd != OPC_READ_ARRAY)
                r_status <= i_din[7:0];
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_cmd   <= i_cmd;
                    r_addr  <= i_cmd_addr;
                    r_data  <= i_cmd_data;
                    r_step  <= 2'd1;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                    r_state <= is_legal(i_cmd) ? ST_OP : ST_FINISH;
                    r_done  <= !is_legal(i_cmd);
                    r_err   <= !is_legal(i_cmd);
                end else begin
                    r_ready <= 1'b1;
                end
                ST_OP: if (w_op_done)
                    r_state <= ST_NEXT;
                ST_NEXT: if (w_start) begin
                    r_state <= ST_OP;
                    if (w_poll_rd)
                        r_cnt <= (r_cnt == POLL_LIMIT) ? r_cnt : r_cnt + 20'd1;
                    else
                        r_step <= r_step + 2'd1;
                end else begin
                    r_state <= ST_FINISH;
                    r_done  <= 1'b1;
                    r_err   <= is_poll(r_cmd) &&
                               (!w_ready_exit || |r_status[SR_ERR_MSB:SR_ERR_LSB]);
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/bpi_cmd_seq.md
# bpi_cmd_seq

Command sequencer for the BPI flash interface FSM: accepts one high-level flash command at a time (read array, program word, block erase, unlock, read/clear status), expands it into the required single-word bus-cycle sequence, and drives the interface FSM's EXECUTE/READ/WRITE handshake. It polls the flash status register until ready, checks error bits, and reports completion. It sits between the configuration/JTAG command decoder and the BPI interface FSM, and is that FSM's only master.

## Interface
- POLL_LIMIT, 20'd1000000: maximum status reads per program/erase poll before timeout.
- CLK  in  1  system clock; all logic on rising edge.
- RST_B  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command request.
- CMD  in  3  opcode: 0 READ_ARRAY, 1 PROGRAM, 2 BLOCK_ERASE, 3 UNLOCK, 4 READ_STATUS, 5 CLEAR_STATUS; 6–7 illegal.
- CMD_ADDR  in  23  word address.
- CMD_DATA  in  16  program data (PROGRAM only).
- CMD_READY  out  1  high only in IDLE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  valid with DONE: illegal opcode, status error or timeout.
- RD_DATA  out  16  last read word (array or status); held until next read.
- STATUS  out  8  last status register value.
- EXECUTE  out  1  one-cycle start pulse to interface FSM.
- READ, WRITE  out  1 each  bus-op direction; exactly one high per op.
- ADDR  out  23  bus-op address.
- DOUT  out  16  bus-op write data.
- BUSY  in  1  interface FSM busy.
- LOAD  in  1  interface FSM read-data strobe.
- DIN  in  16  flash read data, valid when LOAD=1.

## Operation
- Command accepted on CMD_VALID & CMD_READY; CMD, CMD_ADDR, CMD_DATA are registered then.
- Op sequences (W=write, R=read, all at CMD_ADDR):
  - READ_ARRAY: W 0x00FF, R → RD_DATA.
  - PROGRAM: W 0x0040, W CMD_DATA, poll.
  - BLOCK_ERASE: W 0x0020, W 0x00D0, poll.
  - UNLOCK: W 0x0060, W 0x00D0.
  - READ_STATUS: W 0x0070, R → RD_DATA, STATUS=DIN[7:0].
  - CLEAR_STATUS: W 0x0050.
- Poll: W 0x0070, then repeated R; each read updates STATUS; exit when DIN[7]=1. ERR if DIN[5:1]≠0 on exit, or if reads reach POLL_LIMIT (timeout, STATUS holds last value).
- Illegal opcode: no bus ops; DONE=ERR=1 the cycle after acceptance.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, NEXT, POLL_ISSUE, POLL_WAIT, FINISH.
  - IDLE → ISSUE on accept (legal) / FINISH (illegal).
  - ISSUE: EXECUTE=1 one cycle → WAIT_HI.
  - WAIT_HI → WAIT_LO when BUSY=1; WAIT_LO → NEXT when BUSY=0.
  - NEXT → ISSUE (more ops), POLL_ISSUE (PROGRAM/ERASE after 2nd op), FINISH.
  - POLL_ISSUE/POLL_WAIT: read loop as above → FINISH.
  - FINISH: DONE pulse → IDLE.
- READ/WRITE/ADDR/DOUT stable from EXECUTE until BUSY returns low; EXECUTE never issued while BUSY=1.
- Reset values: CMD_READY=0 during reset, 1 first cycle after; DONE, ERR, EXECUTE, READ, WRITE=0; ADDR, DOUT, RD_DATA=0; STATUS=8'h80.
- Reset mid-operation: immediate return to IDLE, no DONE; in-flight flash op abandoned.
- CMD_VALID while busy: ignored, stays pending.

## Timing
- EXECUTE asserted 1 cycle after acceptance.
- Per op: 1 (ISSUE) + interface busy time + 1 (NEXT).
- RD_DATA/STATUS captured on the LOAD cycle.
- DONE 1 cycle after final BUSY fall; CMD_READY the cycle after DONE; back-to-back commands accepted then.
- Poll counter 20 bits, saturates at POLL_LIMIT; never wraps.

## Structure
- Shared package bpi_pkg: opcode constants, flash command codes (0x00FF, 0x0040, 0x0020, 0x00D0, 0x0060, 0x0070, 0x0050), status bit positions, state encoding.
- Sub-module bpi_bus_op: single-op handshake engine (ISSUE/WAIT_HI/WAIT_LO, LOAD capture); sequencer FSM instantiates it once.

## Test plan
- READ_ARRAY addr 0x001234, flash model returns 0xBEEF → W 0x00FF then R; RD_DATA=0xBEEF, DONE=1, ERR=0.
- PROGRAM addr 0x000010 data 0xA5A5, status 0x00 ×3 then 0x80 → ops 0x0040, 0xA5A5, 0x0070, 4 reads; STATUS=0x80, ERR=0.
- BLOCK_ERASE, final status 0xA0 (erase error bit 5) → DONE with ERR=1, STATUS=0xA0.
- PROGRAM with status stuck 0x00, POLL_LIMIT=8 → exactly 8 reads, then DONE, ERR=1.
- CMD=7 → no EXECUTE; DONE=ERR=1 one cycle after accept.
- RST_B low during WAIT_LO of erase → all outputs at reset values; next READ_STATUS completes normally.
